// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses HEADER/ADDR/DHI/DLO/CHK byte frames into register-write requests
module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd5000
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Wr_Valid,
    output logic [7:0]  o_Wr_Addr,
    output logic [15:0] o_Wr_Data,
    input  logic        i_Wr_Ready,
    output logic        o_Err_Chk,
    output logic        o_Err_Ovf,
    output logic        o_Err_Tmo,
    output logic        o_Busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DHI   = 3'd2;
    localparam logic [2:0] S_DLO   = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_chk;
    logic [15:0] r_cnt;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic        r_wr_valid;
    logic        r_err_chk;
    logic        r_err_ovf;
    logic        r_err_tmo;
    logic        r_busy;
    logic        w_run;
    logic        w_tmo;

    assign w_run = (r_state == S_ADDR) || (r_state == S_DHI) || (r_state == S_DLO) || (r_state == S_CHK);
    // A byte arriving on the expiry edge wins over the timeout
    assign w_tmo = w_run && !i_Rx_DV && (r_cnt == TIMEOUT_CLKS - 16'd1);

    // Next-state decode; timeout overrides every receiving state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (i_Rx_DV && i_Rx_Byte == HEADER) ? S_ADDR : S_IDLE;
            S_ADDR:  w_next = i_Rx_DV ? S_DHI : S_ADDR;
            S_DHI:   w_next = i_Rx_DV ? S_DLO : S_DHI;
            S_DLO:   w_next = i_Rx_DV ? S_CHK : S_DLO;
            S_CHK:   w_next = i_Rx_DV ? ((i_Rx_Byte == r_chk) ? S_WRITE : S_IDLE) : S_CHK;
            S_WRITE: w_next = i_Wr_Ready ? S_IDLE : S_WRITE;
            default: w_next = S_IDLE;
        endcase
        if (w_tmo)
            w_next = S_IDLE;
    end

    // State, busy flag, write-valid and error pulses, all registered
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_err_chk  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);
            r_wr_valid <= (w_next == S_WRITE);
            r_err_chk  <= (r_state == S_CHK) && i_Rx_DV && (i_Rx_Byte != r_chk);
            r_err_ovf  <= (r_state == S_WRITE) && i_Rx_DV;
            r_err_tmo  <= w_tmo;
        end
    end

    // Inter-byte counter: held at zero outside the receiving states and on every byte
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L)
            r_cnt <= 16'd0;
        else
            r_cnt <= (i_Rx_DV || !w_run) ? 16'd0 : r_cnt + 16'd1;
    end

    // Field capture and running checksum; fields are kept after the frame ends
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_chk  <= 8'd0;
            r_addr <= 8'd0;
            r_data <= 16'd0;
        end else if (i_Rx_DV) begin
            case (r_state)
                S_IDLE: if (i_Rx_Byte == HEADER) r_chk <= 8'd0;
                S_ADDR: begin
                    r_addr <= i_Rx_Byte;
                    r_chk  <= r_chk ^ i_Rx_Byte;
                end
                S_DHI: begin
                    r_data[15:8] <= i_Rx_Byte;
                    r_chk        <= r_chk ^ i_Rx_Byte;
                end
                S_DLO: begin
                    r_data[7:0] <= i_Rx_Byte;
                    r_chk       <= r_chk ^ i_Rx_Byte;
                end
                default: ;
            endcase
        end
    end

    assign o_Wr_Valid = r_wr_valid;
    assign o_Wr_Addr  = r_addr;
    assign o_Wr_Data  = r_data;
    assign o_Err_Chk  = r_err_chk;
    assign o_Err_Ovf  = r_err_ovf;
    assign o_Err_Tmo  = r_err_tmo;
    assign o_Busy     = r_busy;
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5; frame start byte.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 16'd5000; inter-byte timeout in clocks, legal range 2..65535.
REQ-003 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Rx_DV  input  1  one-cycle byte-valid pulse from the UART receiver.
REQ-006 SHALL have port i_Rx_Byte  input  8  received byte, valid while i_Rx_DV=1.
REQ-007 SHALL have port o_Wr_Valid  output  1  register-write request.
REQ-008 SHALL have port o_Wr_Addr  output  8  write address.
REQ-009 SHALL have port o_Wr_Data  output  16  write data.
REQ-010 SHALL have port i_Wr_Ready  input  1  write accept from the register file.
REQ-011 SHALL have port o_Err_Chk  output  1  one-cycle pulse on checksum mismatch.
REQ-012 SHALL have port o_Err_Ovf  output  1  one-cycle pulse on byte dropped while a write is pending.
REQ-013 SHALL have port o_Err_Tmo  output  1  one-cycle pulse on inter-byte timeout.
REQ-014 SHALL have port o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL parse 5-byte frames: HEADER, ADDR, DHI, DLO, CHK, with CHK = ADDR ^ DHI ^ DLO.
REQ-016 SHALL implement states IDLE, ADDR, DHI, DLO, CHK, WRITE; all outputs registered.
REQ-017 IDLE: i_Rx_DV with byte==HEADER -> ADDR, checksum register cleared to 0; any other byte ignored silently, no error.
REQ-018 ADDR/DHI/DLO: on i_Rx_DV capture byte (ADDR -> address, DHI -> data[15:8], DLO -> data[7:0]), XOR into checksum, advance to next state.
REQ-019 CHK: on i_Rx_DV, byte == checksum -> WRITE with o_Wr_Valid=1 from the same edge; mismatch -> IDLE, o_Err_Chk=1 for exactly the following cycle.
REQ-020 WRITE: o_Wr_Valid, o_Wr_Addr, o_Wr_Data held stable until an edge with o_Wr_Valid=1 and i_Wr_Ready=1; that edge clears o_Wr_Valid and returns to IDLE.
REQ-021 WRITE: any i_Rx_DV, including on the handshake edge, SHALL drop the byte and pulse o_Err_Ovf for one cycle; addr/data unchanged.
REQ-022 Timeout counter (16 bits) SHALL run only in ADDR, DHI, DLO, CHK; cleared on entering ADDR and on every i_Rx_DV.
REQ-023 When the counter reaches TIMEOUT_CLKS-1 with no i_Rx_DV on that edge: -> IDLE, o_Err_Tmo=1 for one cycle; i_Rx_DV on that edge takes priority over the timeout.
REQ-024 o_Wr_Addr/o_Wr_Data SHALL retain last captured values outside WRITE; only o_Wr_Valid qualifies them.
REQ-025 Error pulses SHALL never assert for longer than one cycle and never coincide with o_Wr_Valid rising.

Reset
REQ-026 i_Rst_L=0 SHALL immediately force state IDLE, o_Wr_Valid=0, o_Wr_Addr=0, o_Wr_Data=0, all error pulses 0, o_Busy=0, checksum and counter 0, regardless of clock.
REQ-027 Reset mid-frame or during WRITE SHALL abandon the frame; no write issued after release.
REQ-028 After release, first action SHALL be IDLE header search on the next i_Rx_DV.

Verification
REQ-029 Frame A5 10 12 34 36, i_Wr_Ready=1 -> o_Wr_Valid high exactly one cycle, addr 0x10, data 0x1234, no errors.
REQ-030 Frame A5 10 12 34 37 -> o_Err_Chk one pulse, o_Wr_Valid never asserts, o_Busy low after.
REQ-031 Good frame with i_Wr_Ready=0 for 20 cycles, byte A5 sent during WRITE -> o_Err_Ovf one pulse, valid/addr/data stable; ready=1 -> one transfer, IDLE, A5 not treated as header.
REQ-032 A5 10 then silence -> o_Err_Tmo exactly TIMEOUT_CLKS cycles after the 0x10 DV edge, IDLE; next full frame A5 20 AB CD 46 accepted (addr 0x20, data 0xABCD).
REQ-033 Bytes 00 FF 5A then A5 10 12 34 36 -> leading bytes ignored without errors, single write addr 0x10 data 0x1234.
REQ-034 i_Rst_L pulsed low after A5 10 12, then 34 36 sent -> outputs zero during reset, no write, no errors afterward.
